axi_master_rd_arbiter: RTL

- Shares the single sys_read request port of the AXI master read channel between NUM_REQ requesters.
- Grants one burst at a time using round-robin arbitration.
- Issues the downstream request, then routes the returning read beats to the granted requester.
- Checks beat count against the requested burst size and runs a watchdog timeout.
- Sits between DMA/queue engines and the AXI master; assumes the master is built with MAX_ACTIVE_REQS=1.

---
 rtl/axi_master_rd_arbiter.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_master_rd_arbiter.sv
// axi_master_rd_arbiter
// Round-robin arbiter that shares the single read request port of an AXI
// master between NUM_REQ requesters. One burst is in flight at a time: a
// requester is granted, its request is forwarded downstream, and the returned
// beats are routed back to it. Beat count and RRESP are checked, and a
// watchdog aborts a burst whose data never completes.
module axi_master_rd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clock,
  input  logic                          reset,
  // requester side
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*16-1:0]         req_burst_size,
  input  logic [NUM_REQ-1:0]            req_throttle,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ-1:0]            rsp_last,
  output logic [NUM_REQ-1:0]            rsp_err,
  // AXI master read side
  output logic                          sys_read_req,
  output logic [ADDR_WIDTH-1:0]         sys_read_addr,
  output logic [15:0]                   sys_read_burst_size,
  input  logic                          sys_read_master_ready,
  input  logic [DATA_WIDTH-1:0]         sys_read_data,
  input  logic                          sys_read_data_valid,
  input  logic                          sys_read_data_last,
  input  logic [1:0]                    sys_read_resp,
  output logic                          sys_read_throttle,
  // debug
  output logic [2:0]                    grant_idx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  // Registered state
  state_t                  state_q, state_d;
  logic [2:0]              grant_q, grant_d;
  logic [2:0]              rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             size_q, size_d;
  logic [15:0]             beat_cnt_q, beat_cnt_d;
  logic                    err_q, err_d;            // error seen during current burst
  logic                    zero_err_q, zero_err_d;  // pending pulse for a zero-length request
  logic [31:0]             wd_q, wd_d;              // DATA-state watchdog

  // Combinational helpers
  logic                    pick_found_s;
  logic [2:0]              pick_idx_s;
  logic [ADDR_WIDTH-1:0]   addr_sel_s;
  logic [15:0]             size_sel_s;
  logic                    throttle_sel_s;
  logic [NUM_REQ-1:0]      grant_oh_s;
  logic                    beat_err_s;
  logic                    last_beat_s;
  logic [NUM_REQ-1:0]      req_ready_s;
  logic [NUM_REQ-1:0]      rsp_valid_s;
  logic [NUM_REQ-1:0]      rsp_last_s;
  logic [NUM_REQ-1:0]      rsp_err_s;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [2:0] idx);
    logic [NUM_REQ-1:0] v;
    v = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = (3'(i) == idx);
    end
    return v;
  endfunction

  // Round-robin search starting just after ptr; returns {found, index}.
  // Offsets are scanned from the farthest to the nearest so the nearest
  // valid requester is the one left in the result.
  function automatic logic [3:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                         input logic [2:0]         ptr);
    logic [3:0] res;
    res = 4'b0000;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        res = (valid[i] && (((int'(ptr) + k) % NUM_REQ) == i)) ? {1'b1, 3'(i)} : res;
      end
    end
    return res;
  endfunction

  // Arbitration and per-requester slice selection.
  always_comb begin
    logic [3:0] pick;
    pick           = rr_pick(req_valid, rr_ptr_q);
    pick_found_s   = pick[3];
    pick_idx_s     = pick[2:0];
    addr_sel_s     = {ADDR_WIDTH{1'b0}};
    size_sel_s     = 16'd0;
    throttle_sel_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_sel_s     = (3'(i) == pick_idx_s) ? req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : addr_sel_s;
      size_sel_s     = (3'(i) == pick_idx_s) ? req_burst_size[i*16 +: 16] : size_sel_s;
      throttle_sel_s = (3'(i) == grant_q) ? req_throttle[i] : throttle_sel_s;
    end
    grant_oh_s = to_onehot(grant_q);
  end

  // Next-state logic for the grant/issue/data sequence and its pulses.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    addr_d      = addr_q;
    size_d      = size_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    zero_err_d  = 1'b0;
    wd_d        = wd_q;
    beat_err_s  = 1'b0;
    last_beat_s = sys_read_data_valid & sys_read_data_last;
    req_ready_s = {NUM_REQ{1'b0}};
    rsp_valid_s = {NUM_REQ{1'b0}};
    rsp_last_s  = {NUM_REQ{1'b0}};
    rsp_err_s   = zero_err_q ? grant_oh_s : {NUM_REQ{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (pick_found_s && sys_read_master_ready) begin
          grant_d     = pick_idx_s;
          addr_d      = addr_sel_s;
          size_d      = size_sel_s;
          req_ready_s = to_onehot(pick_idx_s);
          if (size_sel_s == 16'd0) begin
            // nothing to fetch: report it and rotate priority right away
            zero_err_d = 1'b1;
            rr_ptr_d   = pick_idx_s;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        beat_cnt_d = 16'd0;
        wd_d       = 32'd0;
        err_d      = 1'b0;
        state_d    = ST_DATA;
      end

      ST_DATA: begin
        wd_d        = wd_q + 32'd1;
        rsp_valid_s = sys_read_data_valid ? grant_oh_s : {NUM_REQ{1'b0}};
        if (sys_read_data_valid) begin
          beat_cnt_d = beat_cnt_q + 16'd1;
          // size_q is never zero here, so size_q - 1 cannot wrap
          beat_err_s = (sys_read_resp != 2'b00)
                     || (sys_read_data_last && (beat_cnt_q != (size_q - 16'd1)))
                     || (!sys_read_data_last && (beat_cnt_q >= (size_q - 16'd1)));
          err_d      = err_q | beat_err_s;
        end else begin
          beat_cnt_d = beat_cnt_q;
        end

        if (last_beat_s) begin
          rsp_last_s = grant_oh_s;
          rsp_err_s  = err_d ? grant_oh_s : {NUM_REQ{1'b0}};
          rr_ptr_d   = grant_q;
          state_d    = ST_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (wd_q == 32'(TIMEOUT_CYCLES))) begin
          // data never completed: give up and free the port
          rsp_err_s = grant_oh_s;
          rr_ptr_d  = grant_q;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= 3'd0;
      rr_ptr_q   <= 3'(NUM_REQ - 1);
      addr_q     <= {ADDR_WIDTH{1'b0}};
      size_q     <= 16'd0;
      beat_cnt_q <= 16'd0;
      err_q      <= 1'b0;
      zero_err_q <= 1'b0;
      wd_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      zero_err_q <= zero_err_d;
      wd_q       <= wd_d;
    end
  end

  // Output drive; everything is forced low while reset is asserted so a
  // burst cut short by reset produces no stray pulses.
  always_comb begin
    if (reset) begin
      req_ready           = {NUM_REQ{1'b0}};
      rsp_data            = {DATA_WIDTH{1'b0}};
      rsp_valid           = {NUM_REQ{1'b0}};
      rsp_last            = {NUM_REQ{1'b0}};
      rsp_err             = {NUM_REQ{1'b0}};
      sys_read_req        = 1'b0;
      sys_read_addr       = {ADDR_WIDTH{1'b0}};
      sys_read_burst_size = 16'd0;
      sys_read_throttle   = 1'b0;
      grant_idx           = 3'd0;
    end else begin
      req_ready           = req_ready_s;
      rsp_data            = (state_q == ST_DATA) ? sys_read_data : {DATA_WIDTH{1'b0}};
      rsp_valid           = rsp_valid_s;
      rsp_last            = rsp_last_s;
      rsp_err             = rsp_err_s;
      sys_read_req        = (state_q == ST_ISSUE);
      sys_read_addr       = addr_q;
      sys_read_burst_size = size_q;
      sys_read_throttle   = (state_q == ST_DATA) ? throttle_sel_s : 1'b0;
      grant_idx           = grant_q;
    end
  end

endmodule
